// File: rtl/tick_seq_detect.sv
// Tick-qualified "001" sequence detector with Moore level, Mealy pulse and saturating match counter.
// Optional sticky `seen` flag is built when TICK_SEQ_STICKY_EN is defined.
module tick_seq_detect #(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               tick,
  input  logic               x,
  output logic               y_moore,
  output logic               y_mealy,
  output logic [1:0]         state_o,
  output logic [COUNT_W-1:0] match_cnt
`ifdef TICK_SEQ_STICKY_EN
  ,
  output logic               seen
`endif
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 w_match;
  logic [COUNT_W-1:0]   r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S0;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = S0;
    end else if (tick) begin
      unique case (r_state)
        S0: w_next = x ? S0 : S1;
        S1: w_next = x ? S0 : S2;
        S2: w_next = x ? S3 : S2;
        S3: w_next = x ? S0 : S1;
        default: w_next = S0;
      endcase
    end
  end

  // y_mealy ignores clear on purpose; only the counter and flag are gated by it.
  assign y_mealy = tick & x & (r_state == S2);
  assign w_match = y_mealy & ~clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (w_match && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef TICK_SEQ_STICKY_EN
  logic r_seen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_seen <= 1'b0;
    else if (clear)   r_seen <= 1'b0;
    else if (w_match) r_seen <= 1'b1;
  end

  assign seen = r_seen;
`endif

  assign y_moore   = (r_state == S3);
  assign state_o   = r_state;
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_tick_seq_detect.sv
// Self-checking bench for tick_seq_detect: two instances (COUNT_W=8 and COUNT_W=2) checked every
// negedge against a suffix-based reference model; directed scenarios plus a randomized phase.
module tb_tick_seq_detect;

  logic       clk = 1'b0;
  logic       reset, clear, tick, x;
  logic       y_moore_a, y_mealy_a, y_moore_b, y_mealy_b;
  logic [1:0] state_a, state_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
`ifdef TICK_SEQ_STICKY_EN
  logic       seen_a, seen_b;
`endif

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tick_seq_detect #(.COUNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .tick(tick), .x(x),
    .y_moore(y_moore_a), .y_mealy(y_mealy_a), .state_o(state_a), .match_cnt(cnt_a)
`ifdef TICK_SEQ_STICKY_EN
    , .seen(seen_a)
`endif
  );

  tick_seq_detect #(.COUNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .tick(tick), .x(x),
    .y_moore(y_moore_b), .y_mealy(y_mealy_b), .state_o(state_b), .match_cnt(cnt_b)
`ifdef TICK_SEQ_STICKY_EN
    , .seen(seen_b)
`endif
  );

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the last few tick samples since reset/clear and the number of
  // "001" occurrences among them; the state is the longest suffix that is a prefix of "001".
  bit q[$];
  int unsigned n_match = 0;

  function automatic int unsigned mstate();
    int unsigned sz = q.size();
    if (sz >= 3 && q[sz-3] == 1'b0 && q[sz-2] == 1'b0 && q[sz-1] == 1'b1) return 3;
    if (sz >= 2 && q[sz-2] == 1'b0 && q[sz-1] == 1'b0) return 2;
    if (sz >= 1 && q[sz-1] == 1'b0) return 1;
    return 0;
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset || clear) begin
      q.delete();
      n_match = 0;
    end else if (tick) begin
      if (mstate() == 2 && x) n_match++;
      q.push_back(x);
      if (q.size() > 3) void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    int unsigned ms;
    ms = mstate();
    chk("moore_a", y_moore_a, ms == 3);
    chk("mealy_a", y_mealy_a, tick & x & (ms == 2));
    chk("state_a", state_a, ms);
    chk("cnt_a",   cnt_a,   sat(n_match, 255));
    chk("moore_b", y_moore_b, ms == 3);
    chk("mealy_b", y_mealy_b, tick & x & (ms == 2));
    chk("state_b", state_b, ms);
    chk("cnt_b",   cnt_b,   sat(n_match, 3));
`ifdef TICK_SEQ_STICKY_EN
    chk("seen_a", seen_a, n_match > 0);
    chk("seen_b", seen_b, n_match > 0);
`endif
  end

  // One clk cycle: drive inputs, wait for the edge, then settle 2 time units past it.
  task automatic cyc(input logic t, input logic xv, input logic c);
    tick  = t;
    x     = xv;
    clear = c;
    @(posedge clk);
    #2;
  endtask

  // One tick sample followed by gap-1 idle cycles with random x.
  task automatic sample(input logic xv, input int gap);
    cyc(1'b1, xv, 1'b0);
    for (int i = 1; i < gap; i++) cyc(1'b0, 1'($urandom), 1'b0);
  endtask

  int mealy_pulses = 0;
  always @(negedge clk) if (y_mealy_a) mealy_pulses++;

  initial begin
    int exp_b [5];
    logic ov [10];
    exp_b = '{1, 2, 3, 3, 3};
    ov    = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 1};

    reset = 1'b1; clear = 1'b0; tick = 1'b0; x = 1'b0;
    #2;
    // Reset held with ticks running.
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0);
    chk("rst_state", state_a, 0);
    chk("rst_cnt", cnt_a, 0);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    // Single match, tick every 5th cycle.
    sample(1'b0, 5);
    sample(1'b0, 5);
    tick = 1'b1; x = 1'b1; clear = 1'b0;
    #1 chk("single_mealy", y_mealy_a, 1);
    @(posedge clk); #2;
    chk("single_moore", y_moore_a, 1);
    chk("single_cnt", cnt_a, 1);
    for (int i = 1; i < 5; i++) cyc(1'b0, 1'($urandom), 1'b0);
    chk("single_moore_hold", y_moore_a, 1);

    // Async reset mid-period clears outputs without a clk edge.
    reset = 1'b1;
    #1;
    chk("async_moore", y_moore_a, 0);
    chk("async_state", state_a, 0);
    chk("async_cnt", cnt_a, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    // Gating: only tick samples matter.
    for (int i = 0; i < 3; i++) sample(1'b1, 4);
    chk("gate_state", state_a, 0);
    chk("gate_cnt", cnt_a, 0);

    // Overlapping patterns.
    cyc(1'b0, 1'b0, 1'b1);
    mealy_pulses = 0;
    for (int i = 0; i < 10; i++) sample(ov[i], 2);
    chk("ovl_pulses", mealy_pulses, 3);
    chk("ovl_cnt", cnt_a, 3);
    chk("ovl_state", state_a, 3);

    // Saturation on the COUNT_W=2 instance.
    cyc(1'b0, 1'b0, 1'b1);
    for (int m = 0; m < 5; m++) begin
      sample(1'b0, 1);
      sample(1'b0, 1);
      sample(1'b1, 1);
      chk("sat_cnt_b", cnt_b, exp_b[m]);
    end
    chk("sat_cnt_a", cnt_a, 5);
    sample(1'b0, 1);
    sample(1'b0, 1);
    tick = 1'b1; x = 1'b1; clear = 1'b1;
    #1 chk("clr_mealy", y_mealy_b, 1);
    @(posedge clk); #2;
    chk("clr_cnt_b", cnt_b, 0);
    chk("clr_state_b", state_b, 0);

    // Mid-pattern reset loses progress.
    sample(1'b0, 2);
    sample(1'b0, 2);
    reset = 1'b1;
    #3 reset = 1'b0;
    sample(1'b1, 2);
    chk("mid_rst_state", state_a, 0);
    chk("mid_rst_cnt", cnt_a, 0);
    sample(1'b0, 2);
    sample(1'b0, 2);
    sample(1'b1, 2);
    sample(1'b1, 2);
    sample(1'b0, 2);
`ifdef TICK_SEQ_STICKY_EN
    chk("seen_hold", seen_a, 1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("seen_clr", seen_a, 0);
`endif

    // Randomized phase, including consecutive ticks, clears and async resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        #1 reset = 1'b0;
      end
      cyc(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0 ? 1 : 0),
          ($urandom_range(0, 59) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/tick_seq_detect.md
Name: tick_seq_detect

Overview:
- Downstream consumer of the periodic `tick` produced by the tick FSMs (`fsm_tick` / `fsm_tick_en`).
- Samples the serial input `x` only on clock edges where `tick`=1 and detects the bit pattern "001" in those samples.
- Provides a Moore level output, a Mealy single-cycle pulse, and a saturating match counter for the downstream status logic.

Parameters:
- COUNT_W, 8, width of the match counter; counter saturates at 2**COUNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear of FSM state and counter; priority over `tick`.
- tick  input  1  sample strobe, one clk cycle wide; `x` is only examined when `tick`=1.
- x  input  1  serial data bit, stable in any cycle where `tick`=1.
- y_moore  output  1  high while the FSM is in state S3 ("001" just completed).
- y_mealy  output  1  combinational pulse: `tick` & `x` & (state==S2).
- state_o  output  2  current FSM state encoding, for debug and verification.
- match_cnt  output  COUNT_W  saturating count of detected patterns.

Behaviour:
- Interface decided: single clock `clk`; reset `reset` is asynchronous and active-high.
- On reset assertion, immediately and independent of `clk`:
  - state=S0, y_moore=0, match_cnt=0, state_o=2'b00.
  - y_mealy=0, because state≠S2.
- States are encoded S0=00 (idle), S1=01 ("0" seen), S2=10 ("00" seen), S3=11 ("001" seen).
- Transitions occur only on a clk edge with `tick`=1 and `clear`=0; otherwise state holds.
  - S0: x=0 → S1; x=1 → S0.
  - S1: x=0 → S2; x=1 → S0.
  - S2: x=0 → S2; x=1 → S3.
  - S3: x=0 → S1; x=1 → S0.
- y_moore = (state==S3), registered.
  - Rises on the clk edge that samples the final "1".
  - Stays high until the next tick-qualified edge, so it spans one full tick period.
- y_mealy is combinational.
  - High during the same cycle in which `tick`=1 and `x`=1 while in S2.
  - It leads y_moore by exactly one clk cycle and lasts one cycle.
- Match event = (tick & x & state==S2 & !clear).
  - On each match event, match_cnt increments by 1 at the clk edge.
  - At 2**COUNT_W-1 it holds; there is no wrap.
- `clear`=1 at a clk edge:
  - state→S0 and match_cnt→0; any concurrent tick/match is ignored.
  - y_mealy is still evaluated combinationally from the current state, so it may pulse in the clear cycle. The counter ignores that pulse.
- `tick` held high for consecutive cycles: each cycle counts as a separate sample. The block does not detect edges on `tick`.
- Reset asserted mid-pattern: progress is lost and the FSM returns to S0. After reset releases, a full "001" sequence is required again.
- Overlap: a trailing "00" of one stream starts the next match (e.g. 0,0,1,0,0,1 gives 2 matches). From S3, x=0 goes to S1, not S0.
- No combinational path from `x` to any output other than y_mealy.

Optional Feature:
- Macro TICK_SEQ_STICKY_EN.
- When defined:
  - adds output `seen` (1 bit), reset 0;
  - `seen` sets on the first match event and holds until `clear` or `reset`.
- When undefined: the `seen` port and its register do not exist; all other behaviour is identical.

Test Plan:
- Reset check: reset=1 for 20 ns, ticks running → y_moore=0, y_mealy=0, match_cnt=0, state_o=00 throughout; async reset asserted mid-clock-period zeroes outputs without waiting for clk.
- Single match: tick every 5th cycle, samples x=0,0,1 → y_mealy=1 for one cycle on the third tick; y_moore=1 from the next edge for 5 cycles; match_cnt=1.
- Gating: toggle x freely between ticks, x at tick samples=1,1,1 → state stays S0, no outputs, match_cnt=0.
- Overlap: tick samples 0,0,1,0,0,1,0,0,0,1 → three y_mealy pulses, match_cnt=3, final state S3.
- Saturation with COUNT_W=2: five matches → match_cnt sequence 1,2,3,3,3; then clear=1 for one cycle with tick=1, x=1, state=S2 → match_cnt=0, state S0.
- Mid-pattern reset: samples 0,0, then reset pulse, then sample 1 → no match, state S0; with TICK_SEQ_STICKY_EN, seen=1 after the first later match and stays 1 across further ticks until clear.
